// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master, three-slave serial bus controller.
package bus_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR1   = 3'd1,
      ADDR0   = 3'd2,
      DECODE  = 3'd3,
      CONNECT = 3'd4,
      RELEASE = 3'd5
   } bus_state_e;

   localparam logic [1:0] SLV0    = 2'd0;
   localparam logic [1:0] SLV1    = 2'd1;
   localparam logic [1:0] SLV2    = 2'd2;
   localparam logic [1:0] SLV_INV = 2'd3;

   localparam int DEF_TIMEOUT_CYC = 255;

   // One-hot slave select for an ID; the invalid ID maps to no slave at all.
   function automatic logic [2:0] slv_onehot(input logic [1:0] id);
      logic [2:0] oh;
      case (id)
         SLV0:    oh = 3'b001;
         SLV1:    oh = 3'b010;
         SLV2:    oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter; prio names the master that wins a tie.
module rr_arbiter_2
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       update,
   input  logic       served,
   output logic [1:0] gnt,
   output logic       gnt_idx
);

   logic prio;

   always_comb begin
      gnt_idx = prio;
      gnt     = 2'b00;
      if (req[prio]) begin
         gnt_idx = prio;
      end else if (req[~prio]) begin
         gnt_idx = ~prio;
      end
      if (req != 2'b00) begin
         gnt = 2'b01 << gnt_idx;
      end
   end

   // After serving a master, the other one gets priority on the next tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio <= 1'b0;
      end else if (update) begin
         prio <= ~served;
      end
   end

endmodule

// File: rtl/bus_controller.sv
// Serial bus controller: arbitrates two masters, shifts in a 2-bit slave ID,
// connects the granted master to one of three slaves, and supervises completion.
module bus_controller
   import bus_pkg::*;
#(
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] m_req,
   output logic [1:0] m_grant,
   input  logic [1:0] m_sout,
   output logic       m_sin,
   output logic       m_ack,
   output logic       m_nack,
   output logic       m_done,
   output logic [2:0] s_sel,
   output logic       s_bus,
   input  logic [2:0] s_bus_in,
   input  logic [2:0] s_util,
   output logic [2:0] s_ack,
   input  logic [2:0] s_done,
   output logic [2:0] dbg_state
);

   // Timeout fires on the edge that ends the TIMEOUT_CYC-th CONNECT cycle.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

   bus_state_e state, state_d;
   logic       gnt_idx;
   logic [1:0] slv_id;
   logic [7:0] cnt;

   logic [1:0] arb_gnt;
   logic       arb_idx;

   logic [2:0] sel_oh;
   logic       req_held, id_bad, slv_busy, done_hit, timeout_hit;

   logic [1:0] grant_d;
   logic [2:0] sel_d, s_ack_d;
   logic       ack_d, nack_d, done_d;

   rr_arbiter_2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (m_req),
      .update  (state == RELEASE),
      .served  (gnt_idx),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   assign sel_oh      = slv_onehot(slv_id);
   assign req_held    = m_req[gnt_idx];
   assign id_bad      = (slv_id == SLV_INV);
   assign slv_busy    = |(s_util & sel_oh);
   assign done_hit    = |(s_done & sel_oh);
   assign timeout_hit = (cnt == TO_LAST);

   // Data paths are live only while connected so idle slaves see a quiet bus.
   assign s_bus     = (state == CONNECT) && m_sout[gnt_idx];
   assign m_sin     = (state == CONNECT) && |(s_bus_in & sel_oh);
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         m_grant <= 2'b00;
         s_sel   <= 3'b000;
         s_ack   <= 3'b000;
         m_ack   <= 1'b0;
         m_nack  <= 1'b0;
         m_done  <= 1'b0;
      end else begin
         state   <= state_d;
         m_grant <= grant_d;
         s_sel   <= sel_d;
         s_ack   <= s_ack_d;
         m_ack   <= ack_d;
         m_nack  <= nack_d;
         m_done  <= done_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_idx <= 1'b0;
         slv_id  <= 2'b00;
         cnt     <= 8'd0;
      end else begin
         case (state)
            IDLE:    if (|m_req) gnt_idx <= arb_idx;
            ADDR1:   slv_id[1] <= m_sout[gnt_idx];
            ADDR0:   slv_id[0] <= m_sout[gnt_idx];
            DECODE:  cnt <= 8'd0;
            CONNECT: cnt <= cnt + 8'd1;
            default: ;
         endcase
      end
   end

   // A dropped request always wins: the transaction is abandoned silently.
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (|m_req) state_d = ADDR1;
         ADDR1:   state_d = req_held ? ADDR0 : RELEASE;
         ADDR0:   state_d = req_held ? DECODE : RELEASE;
         DECODE:  state_d = (req_held && !id_bad && !slv_busy) ? CONNECT : RELEASE;
         CONNECT: if (!req_held || done_hit || timeout_hit) state_d = RELEASE;
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_d = m_grant;
      sel_d   = s_sel;
      s_ack_d = 3'b000;
      ack_d   = 1'b0;
      nack_d  = 1'b0;
      done_d  = 1'b0;
      case (state)
         IDLE: begin
            if (|m_req) grant_d = arb_gnt;
         end
         DECODE: begin
            if (req_held) begin
               if (id_bad || slv_busy) begin
                  nack_d = 1'b1;
               end else begin
                  sel_d   = sel_oh;
                  s_ack_d = sel_oh;
                  ack_d   = 1'b1;
               end
            end
         end
         CONNECT: begin
            // Completion takes precedence over a coincident timeout.
            if (req_held) begin
               if (done_hit) begin
                  done_d = 1'b1;
               end else if (timeout_hit) begin
                  nack_d = 1'b1;
               end
            end
         end
         default: ;
      endcase
      if (state_d == RELEASE) begin
         grant_d = 2'b00;
         sel_d   = 3'b000;
      end
   end

endmodule

// File: tb/tb_bus_controller.sv
// Directed bench for bus_controller with a pulse scoreboard and timing checks.
module tb_bus_controller;
  import bus_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] m_req;
  logic [1:0] m_grant;
  logic [1:0] m_sout;
  logic       m_sin;
  logic       m_ack, m_nack, m_done;
  logic [2:0] s_sel;
  logic       s_bus;
  logic [2:0] s_bus_in, s_util, s_ack, s_done;
  logic [2:0] dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Event word: {m_ack, m_nack, m_done, m_grant, s_sel, s_ack}
  logic [10:0] exp_q[$];
  int          exp_cyc_q[$];

  bus_controller #(.TIMEOUT_CYC(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m_req     (m_req),
    .m_grant   (m_grant),
    .m_sout    (m_sout),
    .m_sin     (m_sin),
    .m_ack     (m_ack),
    .m_nack    (m_nack),
    .m_done    (m_done),
    .s_sel     (s_sel),
    .s_bus     (s_bus),
    .s_bus_in  (s_bus_in),
    .s_util    (s_util),
    .s_ack     (s_ack),
    .s_done    (s_done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / driver tasks ----------------
  function automatic logic [10:0] ev(input logic a, input logic n, input logic d,
                                     input logic [1:0] g, input logic [2:0] sel,
                                     input logic [2:0] sa);
    return {a, n, d, g, sel, sa};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [10:0] e, input int c);
    exp_q.push_back(e);
    exp_cyc_q.push_back(c);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    m_req    = 2'b00;
    m_sout   = 2'b00;
    s_bus_in = 3'b000;
    s_util   = 3'b000;
    s_done   = 3'b000;
    rst_n    = 1'b0;
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic wait_grant(input int m, output int gc);
    int n;
    n = 0;
    do begin
      tick;
      n++;
    end while (!m_grant[m] && n < 50);
    gc = cyc;
    chk("grant_seen", 32'(m_grant[m]), 32'd1);
  endtask

  // Master shifts its slave ID out MSB first, one bit per cycle after grant.
  task automatic send_addr(input int m, input logic [1:0] id);
    m_sout[m] = id[1];
    tick;
    m_sout[m] = id[0];
    tick;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [10:0] act, exp;
    int          ec;
    checks++;
    if ($countones(m_grant) > 1 || $countones(s_sel) > 1) begin
      errors++;
      $display("FAIL onehot: grant=%b sel=%b (cycle %0d)", m_grant, s_sel, cyc);
    end
    if (rst_n && (m_ack || m_nack || m_done || (s_ack != 3'b000))) begin
      act = {m_ack, m_nack, m_done, m_grant, s_sel, s_ack};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got %h expected none (cycle %0d)", act, cyc);
      end else begin
        exp = exp_q.pop_front();
        ec  = exp_cyc_q.pop_front();
        if (act !== exp || cyc != ec) begin
          errors++;
          $display("FAIL sb_event: got %h at cycle %0d expected %h at cycle %0d",
                   act, cyc, exp, ec);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int c, gc, rc;
    rst_n    = 1'b0;
    m_req    = 2'b00;
    m_sout   = 2'b00;
    s_bus_in = 3'b000;
    s_util   = 3'b000;
    s_done   = 3'b000;
    #3;
    chk("rst_grant", 32'(m_grant), 32'd0);
    chk("rst_sel", 32'(s_sel), 32'd0);
    chk("rst_pulses", 32'({m_ack, m_nack, m_done}), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    do_reset;

    // Master 0 -> slave 1, completion by S_DONE.
    m_req = 2'b01;
    c = cyc;
    wait_grant(0, gc);
    chk("s1_grant_cycle", 32'(gc - c), 32'd1);
    chk("s1_grant_val", 32'(m_grant), 32'b01);
    chk("s1_state_addr1", 32'(dbg_state), 32'(ADDR1));
    push(ev(1, 0, 0, 2'b01, 3'b010, 3'b010), gc + 3);
    send_addr(0, 2'b01);
    tick;
    m_sout[0] = 1'b1;
    s_bus_in  = 3'b010;
    #1;
    chk("s1_sbus_hi", 32'(s_bus), 32'd1);
    chk("s1_msin_hi", 32'(m_sin), 32'd1);
    m_sout[0] = 1'b0;
    s_bus_in  = 3'b101;
    #1;
    chk("s1_sbus_lo", 32'(s_bus), 32'd0);
    chk("s1_msin_lo", 32'(m_sin), 32'd0);
    tick;
    tick;
    s_done = 3'b010;
    push(ev(0, 0, 1, 2'b00, 3'b000, 3'b000), cyc + 1);
    tick;
    chk("s1_release_grant", 32'(m_grant), 32'd0);
    chk("s1_release_state", 32'(dbg_state), 32'(RELEASE));
    s_done   = 3'b000;
    s_bus_in = 3'b000;
    m_req    = 2'b00;
    tick;
    chk("s1_idle_sbus", 32'(s_bus), 32'd0);

    // Both masters request together after reset: master 0 first, then master 1.
    do_reset;
    m_req = 2'b11;
    c = cyc;
    wait_grant(0, gc);
    chk("s2_m0_first", 32'(m_grant), 32'b01);
    chk("s2_grant_cycle", 32'(gc - c), 32'd1);
    push(ev(1, 0, 0, 2'b01, 3'b001, 3'b001), gc + 3);
    send_addr(0, 2'b00);
    tick;
    s_done = 3'b001;
    push(ev(0, 0, 1, 2'b00, 3'b000, 3'b000), cyc + 1);
    tick;
    rc = cyc;
    s_done   = 3'b000;
    m_req[0] = 1'b0;
    wait_grant(1, gc);
    chk("s2_m1_gap", 32'(gc - rc), 32'd2);
    chk("s2_m1_grant", 32'(m_grant), 32'b10);
    push(ev(1, 0, 0, 2'b10, 3'b100, 3'b100), gc + 3);
    send_addr(1, 2'b10);
    tick;
    m_req[1] = 1'b0;   // drop in CONNECT: silent release
    tick;
    chk("s2_drop_state", 32'(dbg_state), 32'(RELEASE));
    chk("s2_drop_grant", 32'(m_grant), 32'd0);
    chk("s2_drop_sel", 32'(s_sel), 32'd0);
    tick;

    // Invalid ID 11 -> NACK, no slave selected.
    m_req = 2'b01;
    wait_grant(0, gc);
    push(ev(0, 1, 0, 2'b00, 3'b000, 3'b000), gc + 3);
    send_addr(0, 2'b11);
    chk("s3_decode_sel", 32'(s_sel), 32'd0);
    tick;
    chk("s3_nack_sel", 32'(s_sel), 32'd0);
    m_req = 2'b00;
    tick;

    // Busy slave 2 -> NACK, no S_ACK.
    m_req  = 2'b10;
    s_util = 3'b100;
    wait_grant(1, gc);
    push(ev(0, 1, 0, 2'b00, 3'b000, 3'b000), gc + 3);
    send_addr(1, 2'b10);
    tick;
    chk("s3_busy_sack", 32'(s_ack), 32'd0);
    m_req  = 2'b00;
    s_util = 3'b000;
    tick;

    // Timeout with TIMEOUT_CYC=10: NACK 10 cycles after CONNECT entry.
    m_req = 2'b01;
    wait_grant(0, gc);
    push(ev(1, 0, 0, 2'b01, 3'b100, 3'b100), gc + 3);
    push(ev(0, 1, 0, 2'b00, 3'b000, 3'b000), gc + 13);
    send_addr(0, 2'b10);
    tick;
    c = 0;
    while (dbg_state == 3'(CONNECT) && c < 40) begin
      tick;
      c++;
    end
    chk("s4_to_release", 32'(dbg_state), 32'(RELEASE));
    m_req = 2'b00;
    tick;
    chk("s4_to_idle", 32'(dbg_state), 32'(IDLE));

    // S_DONE coincides with timeout: DONE only.
    m_req = 2'b01;
    wait_grant(0, gc);
    push(ev(1, 0, 0, 2'b01, 3'b001, 3'b001), gc + 3);
    send_addr(0, 2'b00);
    tick;
    repeat (9) tick;
    s_done = 3'b001;
    push(ev(0, 0, 1, 2'b00, 3'b000, 3'b000), cyc + 1);
    tick;
    chk("s5_coinc_state", 32'(dbg_state), 32'(RELEASE));
    s_done = 3'b000;
    m_req  = 2'b00;
    tick;

    // Reset mid-CONNECT, then master 0 wins the first request afterwards.
    m_req = 2'b10;
    wait_grant(1, gc);
    push(ev(1, 0, 0, 2'b10, 3'b010, 3'b010), gc + 3);
    send_addr(1, 2'b01);
    m_sout[1] = 1'b1;
    tick;
    chk("s6_sbus_m1", 32'(s_bus), 32'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("s6_rst_grant", 32'(m_grant), 32'd0);
    chk("s6_rst_sel", 32'(s_sel), 32'd0);
    chk("s6_rst_sbus", 32'(s_bus), 32'd0);
    chk("s6_rst_state", 32'(dbg_state), 32'(IDLE));
    tick;
    tick;
    m_req  = 2'b00;
    m_sout = 2'b00;
    rst_n  = 1'b1;
    tick;
    m_req = 2'b11;
    c = cyc;
    wait_grant(0, gc);
    chk("s6_post_rst_m0", 32'(m_grant), 32'b01);
    chk("s6_post_rst_cycle", 32'(gc - c), 32'd1);
    m_req = 2'b00;     // drop in ADDR1: silent release
    tick;
    chk("s6_addr1_drop", 32'(dbg_state), 32'(RELEASE));
    chk("s6_addr1_grant", 32'(m_grant), 32'd0);
    repeat (3) tick;

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
